// File: rtl/tile_config_sequencer.sv
// rtl/tile_config_sequencer.sv - byte-stream parser driving the broadcast tile configuration bus
module tile_config_sequencer #(
    parameter int NTILES = 16,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              conf,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [NTILES-1:0] select_tile,
    output logic [ADDR_W-1:0] address_tile,
    output logic [DATA_W-1:0] data_tile,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        frame_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_H_TILE = 3'd1;
    localparam logic [2:0] S_H_ALO  = 3'd2;
    localparam logic [2:0] S_H_AHI  = 3'd3;
    localparam logic [2:0] S_H_CLO  = 3'd4;
    localparam logic [2:0] S_H_CHI  = 3'd5;
    localparam logic [2:0] S_DATA   = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [NTILES-1:0] sel_mask_q, sel_mask_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic [NTILES-1:0] select_tile_q, select_tile_d;
    logic [ADDR_W-1:0] address_tile_q, address_tile_d;
    logic [DATA_W-1:0] data_tile_q, data_tile_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic       accept;
    logic [7:0] in_byte;
    logic [7:0] frame_cnt_inc;

    assign accept        = in_valid && in_ready_q;
    assign in_byte       = in_data[7:0];
    assign frame_cnt_inc = (frame_cnt_q == 8'hFF) ? frame_cnt_q : frame_cnt_q + 8'd1;

    always_comb begin
        state_d        = state_q;
        sel_mask_d     = sel_mask_q;
        addr_d         = addr_q;
        cnt_d          = cnt_q;
        err_d          = err_q;
        frame_cnt_d    = frame_cnt_q;
        select_tile_d  = '0;
        address_tile_d = address_tile_q;
        data_tile_d    = data_tile_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_H_TILE;
                    err_d       = 1'b0;
                    frame_cnt_d = 8'd0;
                end
            end
            S_H_TILE: begin
                if (accept) begin
                    if (in_byte == 8'hFF) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_H_ALO;
                        // An out-of-range id still parses its frame, but with an empty strobe mask
                        if (int'(in_byte) < NTILES) begin
                            sel_mask_d = NTILES'(1) << in_byte;
                        end else begin
                            sel_mask_d = '0;
                            err_d      = 1'b1;
                        end
                    end
                end
            end
            S_H_ALO: begin
                if (accept) begin
                    addr_d[7:0] = in_byte;
                    state_d     = S_H_AHI;
                end
            end
            S_H_AHI: begin
                if (accept) begin
                    addr_d[ADDR_W-1:8] = in_data[ADDR_W-9:0];
                    state_d            = S_H_CLO;
                end
            end
            S_H_CLO: begin
                if (accept) begin
                    cnt_d[7:0] = in_byte;
                    state_d    = S_H_CHI;
                end
            end
            S_H_CHI: begin
                if (accept) begin
                    cnt_d[15:8] = in_byte;
                    if ({in_byte, cnt_q[7:0]} == 16'd0) begin
                        state_d     = S_H_TILE;
                        frame_cnt_d = frame_cnt_inc;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    select_tile_d = sel_mask_q;
                    if (|sel_mask_q) begin
                        address_tile_d = addr_q;
                        data_tile_d    = in_data;
                    end
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d     = S_H_TILE;
                        frame_cnt_d = frame_cnt_inc;
                    end
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags are registered from the next state so they line up with it
        in_ready_d = (state_d != S_IDLE) && (state_d != S_DONE);
        busy_d     = in_ready_d;
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge conf) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            sel_mask_q     <= '0;
            addr_q         <= '0;
            cnt_q          <= '0;
            err_q          <= 1'b0;
            frame_cnt_q    <= 8'd0;
            select_tile_q  <= '0;
            address_tile_q <= '0;
            data_tile_q    <= '0;
            in_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            sel_mask_q     <= sel_mask_d;
            addr_q         <= addr_d;
            cnt_q          <= cnt_d;
            err_q          <= err_d;
            frame_cnt_q    <= frame_cnt_d;
            select_tile_q  <= select_tile_d;
            address_tile_q <= address_tile_d;
            data_tile_q    <= data_tile_d;
            in_ready_q     <= in_ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign select_tile  = select_tile_q;
    assign address_tile = address_tile_q;
    assign data_tile    = data_tile_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_tile_config_sequencer.sv
// tb/tb_tile_config_sequencer.sv - directed vector table plus scoreboarded random frames
module tb_tile_config_sequencer;

    logic        conf = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] select_tile;
    logic [9:0]  address_tile;
    logic [7:0]  data_tile;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  frame_cnt;

    int errors = 0;
    int checks = 0;

    tile_config_sequencer #(.NTILES(16), .ADDR_W(10), .DATA_W(8)) dut (
        .conf(conf), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .select_tile(select_tile), .address_tile(address_tile), .data_tile(data_tile),
        .busy(busy), .done(done), .err(err), .frame_cnt(frame_cnt)
    );

    always #5 conf = ~conf;

    typedef struct {
        logic        st;
        logic        v;
        logic [7:0]  b;
        logic [15:0] sel;
        logic [9:0]  addr;
        logic [7:0]  data;
        logic [7:0]  fc;
        logic        dn;
        logic        bz;
        logic        er;
        logic        rd;
    } vec_t;

    typedef struct {
        logic [15:0] sel;
        logic [9:0]  addr;
        logic [7:0]  data;
    } wr_t;

    vec_t vecs[$];
    wr_t  exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tv(input logic st, input logic v, input logic [7:0] b, input logic [15:0] sel,
                      input logic [9:0] a, input logic [7:0] d, input logic [7:0] fc,
                      input logic dn, input logic bz, input logic er, input logic rd);
        vecs.push_back('{st, v, b, sel, a, d, fc, dn, bz, er, rd});
    endtask

    task automatic step(input logic st, input logic v, input logic [7:0] b);
        start    = st;
        in_valid = v;
        in_data  = b;
        @(posedge conf);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    // Step used in the random phase: any strobe must match the head of the scoreboard
    task automatic rstep(input logic v, input logic [7:0] b);
        wr_t w;
        step(1'b0, v, b);
        if (select_tile != 16'h0) begin
            if (exp_q.size() == 0) begin
                chk("rnd_unexpected_write", {16'h0, select_tile}, 32'h0);
            end else begin
                w = exp_q.pop_front();
                chk("rnd_sel", {16'h0, select_tile}, {16'h0, w.sel});
                chk("rnd_addr", {22'h0, address_tile}, {22'h0, w.addr});
                chk("rnd_data", {24'h0, data_tile}, {24'h0, w.data});
            end
        end
    endtask

    task automatic rsend(input logic [7:0] b);
        while ($urandom_range(0, 2) == 0) rstep(1'b0, 8'h00);
        rstep(1'b1, b);
    endtask

    initial begin
        logic [7:0]  hi_rand;
        logic [3:0]  tile;
        logic [9:0]  addr;
        logic [7:0]  cnt;
        logic [7:0]  pb;

        // Basic frame to tile 3
        tv(1,0,8'h00, 16'h0000,10'h000,8'h00, 8'd0, 0,1,0,1);
        tv(0,1,8'h03, 16'h0000,10'h000,8'h00, 8'd0, 0,1,0,1);
        tv(0,1,8'h10, 16'h0000,10'h000,8'h00, 8'd0, 0,1,0,1);
        tv(0,1,8'h00, 16'h0000,10'h000,8'h00, 8'd0, 0,1,0,1);
        tv(0,1,8'h03, 16'h0000,10'h000,8'h00, 8'd0, 0,1,0,1);
        tv(0,1,8'h00, 16'h0000,10'h000,8'h00, 8'd0, 0,1,0,1);
        tv(0,1,8'hAA, 16'h0008,10'h010,8'hAA, 8'd0, 0,1,0,1);
        tv(0,1,8'hBB, 16'h0008,10'h011,8'hBB, 8'd0, 0,1,0,1);
        tv(0,1,8'hCC, 16'h0008,10'h012,8'hCC, 8'd1, 0,1,0,1);
        tv(0,1,8'hFF, 16'h0000,10'h012,8'hCC, 8'd1, 1,0,0,0);
        tv(0,0,8'h00, 16'h0000,10'h012,8'hCC, 8'd1, 0,0,0,0);
        // Stalls between payload bytes and address wrap at 0x3FF
        tv(1,0,8'h00, 16'h0000,10'h012,8'hCC, 8'd0, 0,1,0,1);
        tv(0,1,8'h00, 16'h0000,10'h012,8'hCC, 8'd0, 0,1,0,1);
        tv(0,1,8'hFE, 16'h0000,10'h012,8'hCC, 8'd0, 0,1,0,1);
        tv(0,1,8'h03, 16'h0000,10'h012,8'hCC, 8'd0, 0,1,0,1);
        tv(0,1,8'h04, 16'h0000,10'h012,8'hCC, 8'd0, 0,1,0,1);
        tv(0,1,8'h00, 16'h0000,10'h012,8'hCC, 8'd0, 0,1,0,1);
        tv(0,1,8'hD0, 16'h0001,10'h3FE,8'hD0, 8'd0, 0,1,0,1);
        tv(0,0,8'h55, 16'h0000,10'h3FE,8'hD0, 8'd0, 0,1,0,1);
        tv(0,1,8'hD1, 16'h0001,10'h3FF,8'hD1, 8'd0, 0,1,0,1);
        tv(0,0,8'h55, 16'h0000,10'h3FF,8'hD1, 8'd0, 0,1,0,1);
        tv(0,1,8'hD2, 16'h0001,10'h000,8'hD2, 8'd0, 0,1,0,1);
        tv(0,0,8'h55, 16'h0000,10'h000,8'hD2, 8'd0, 0,1,0,1);
        tv(0,1,8'hD3, 16'h0001,10'h001,8'hD3, 8'd1, 0,1,0,1);
        tv(0,1,8'hFF, 16'h0000,10'h001,8'hD3, 8'd1, 1,0,0,0);
        tv(0,0,8'h00, 16'h0000,10'h001,8'hD3, 8'd1, 0,0,0,0);
        // Bad tile id 0x20, then a good frame to tile 1
        tv(1,0,8'h00, 16'h0000,10'h001,8'hD3, 8'd0, 0,1,0,1);
        tv(0,1,8'h20, 16'h0000,10'h001,8'hD3, 8'd0, 0,1,1,1);
        tv(0,1,8'h00, 16'h0000,10'h001,8'hD3, 8'd0, 0,1,1,1);
        tv(0,1,8'h00, 16'h0000,10'h001,8'hD3, 8'd0, 0,1,1,1);
        tv(0,1,8'h02, 16'h0000,10'h001,8'hD3, 8'd0, 0,1,1,1);
        tv(0,1,8'h00, 16'h0000,10'h001,8'hD3, 8'd0, 0,1,1,1);
        tv(0,1,8'h11, 16'h0000,10'h001,8'hD3, 8'd0, 0,1,1,1);
        tv(0,1,8'h22, 16'h0000,10'h001,8'hD3, 8'd1, 0,1,1,1);
        tv(0,1,8'h01, 16'h0000,10'h001,8'hD3, 8'd1, 0,1,1,1);
        tv(0,1,8'h20, 16'h0000,10'h001,8'hD3, 8'd1, 0,1,1,1);
        tv(0,1,8'h00, 16'h0000,10'h001,8'hD3, 8'd1, 0,1,1,1);
        tv(0,1,8'h02, 16'h0000,10'h001,8'hD3, 8'd1, 0,1,1,1);
        tv(0,1,8'h00, 16'h0000,10'h001,8'hD3, 8'd1, 0,1,1,1);
        tv(0,1,8'h33, 16'h0002,10'h020,8'h33, 8'd1, 0,1,1,1);
        tv(0,1,8'h44, 16'h0002,10'h021,8'h44, 8'd2, 0,1,1,1);
        tv(0,1,8'hFF, 16'h0000,10'h021,8'h44, 8'd2, 1,0,1,0);
        tv(0,0,8'h00, 16'h0000,10'h021,8'h44, 8'd2, 0,0,1,0);
        // Zero-count frame, start while busy, start held in DONE
        tv(1,0,8'h00, 16'h0000,10'h021,8'h44, 8'd0, 0,1,0,1);
        tv(0,1,8'h05, 16'h0000,10'h021,8'h44, 8'd0, 0,1,0,1);
        tv(0,1,8'h00, 16'h0000,10'h021,8'h44, 8'd0, 0,1,0,1);
        tv(0,1,8'h00, 16'h0000,10'h021,8'h44, 8'd0, 0,1,0,1);
        tv(0,1,8'h00, 16'h0000,10'h021,8'h44, 8'd0, 0,1,0,1);
        tv(0,1,8'h00, 16'h0000,10'h021,8'h44, 8'd1, 0,1,0,1);
        tv(1,0,8'h00, 16'h0000,10'h021,8'h44, 8'd1, 0,1,0,1);
        tv(0,1,8'hFF, 16'h0000,10'h021,8'h44, 8'd1, 1,0,0,0);
        tv(1,0,8'h00, 16'h0000,10'h021,8'h44, 8'd1, 1,0,0,0);
        tv(0,0,8'h00, 16'h0000,10'h021,8'h44, 8'd1, 0,0,0,0);

        reset = 1'b0;
        repeat (2) @(posedge conf);
        #1;
        chk("reset_ready", {31'h0, in_ready}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].st, vecs[i].v, vecs[i].b);
            chk($sformatf("v%0d_sel", i), {16'h0, select_tile}, {16'h0, vecs[i].sel});
            chk($sformatf("v%0d_addr", i), {22'h0, address_tile}, {22'h0, vecs[i].addr});
            chk($sformatf("v%0d_data", i), {24'h0, data_tile}, {24'h0, vecs[i].data});
            chk($sformatf("v%0d_fcnt", i), {24'h0, frame_cnt}, {24'h0, vecs[i].fc});
            chk($sformatf("v%0d_done", i), {31'h0, done}, {31'h0, vecs[i].dn});
            chk($sformatf("v%0d_busy", i), {31'h0, busy}, {31'h0, vecs[i].bz});
            chk($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, vecs[i].er});
            chk($sformatf("v%0d_ready", i), {31'h0, in_ready}, {31'h0, vecs[i].rd});
        end

        // Reset in the middle of a payload: frame to tile 2 at 0x100, two of three bytes written
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h02);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'h03);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'h02);
        chk("mid_sel", {16'h0, select_tile}, 32'h0004);
        chk("mid_addr", {22'h0, address_tile}, 32'h101);
        chk("mid_data", {24'h0, data_tile}, 32'h02);
        reset = 1'b0;
        step(1'b0, 1'b1, 8'h03);
        reset = 1'b1;
        chk("rst_sel", {16'h0, select_tile}, 32'h0);
        chk("rst_addr", {22'h0, address_tile}, 32'h0);
        chk("rst_data", {24'h0, data_tile}, 32'h0);
        chk("rst_ready", {31'h0, in_ready}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_fcnt", {24'h0, frame_cnt}, 32'h0);
        step(1'b0, 1'b1, 8'h07);
        chk("idle_ignores_byte", {31'h0, in_ready}, 32'h0);
        step(1'b1, 1'b0, 8'h00);
        chk("restart_busy", {31'h0, busy}, 32'h1);
        step(1'b0, 1'b1, 8'h07);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'h00);
        chk("restart_no_hdr_strobe", {16'h0, select_tile}, 32'h0);
        step(1'b0, 1'b1, 8'h5A);
        chk("restart_sel", {16'h0, select_tile}, 32'h0080);
        chk("restart_addr", {22'h0, address_tile}, 32'h000);
        chk("restart_data", {24'h0, data_tile}, 32'h5A);
        chk("restart_fcnt", {24'h0, frame_cnt}, 32'h1);
        step(1'b0, 1'b1, 8'hFF);
        chk("restart_done", {31'h0, done}, 32'h1);
        step(1'b0, 1'b0, 8'h00);

        // Random frames with scoreboard
        step(1'b1, 1'b0, 8'h00);
        for (int f = 0; f < 200; f++) begin
            tile    = 4'($urandom_range(0, 15));
            addr    = 10'($urandom_range(0, 1023));
            cnt     = 8'($urandom_range(0, 40));
            hi_rand = 8'($urandom);
            rsend({4'h0, tile});
            rsend(addr[7:0]);
            rsend({hi_rand[7:2], addr[9:8]});
            rsend(cnt);
            rsend(8'h00);
            for (int k = 0; k < int'(cnt); k++) begin
                pb = 8'($urandom);
                exp_q.push_back('{16'h1 << tile, addr + 10'(k), pb});
                rsend(pb);
            end
        end
        rsend(8'hFF);
        chk("rnd_done", {31'h0, done}, 32'h1);
        chk("rnd_busy", {31'h0, busy}, 32'h0);
        chk("rnd_fcnt", {24'h0, frame_cnt}, 32'd200);
        chk("rnd_err", {31'h0, err}, 32'h0);
        chk("rnd_missing_writes", exp_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
